// File: rtl/fifo_rd_stream.sv
// Read-side drain engine: pops a registered-read FIFO and re-times its words into a valid/ready stream
// through a 2-entry skid buffer. Optional statistics counters are enabled with `define FIFO_RD_STATS_EN.
module fifo_rd_stream #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fifo_empty,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_rdata,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  input  logic                  m_ready,
  input  logic                  flush,
  output logic                  busy
`ifdef FIFO_RD_STATS_EN
  ,
  output logic [CNT_WIDTH-1:0]  pop_count,
  output logic [CNT_WIDTH-1:0]  stall_count
`endif
);

  if (DATA_WIDTH < 1 || CNT_WIDTH < 1) begin : g_param_chk
    $error("fifo_rd_stream: DATA_WIDTH and CNT_WIDTH must be positive");
  end

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_e;

  occ_e                  occ;
  occ_e                  occ_nxt;
  logic                  inflight;
  logic                  pop;
  logic [1:0]            credits;
  logic [DATA_WIDTH-1:0] word_p0;
  logic [DATA_WIDTH-1:0] word_p1;

  // Request stage: a read is allowed only if its word is guaranteed a buffer slot on arrival.
  assign pop        = m_valid && m_ready;
  assign credits    = occ + {1'b0, inflight} - {1'b0, pop};
  assign fifo_rd_en = !fifo_empty && !flush && !rst && (credits < 2'd2);

  always_comb begin
    occ_nxt = occ;
    case (occ)
      OCC_EMPTY: if (inflight) occ_nxt = OCC_ONE;
      OCC_ONE: begin
        if (inflight && !pop)      occ_nxt = OCC_TWO;
        else if (!inflight && pop) occ_nxt = OCC_EMPTY;
      end
      OCC_TWO: if (pop && !inflight) occ_nxt = OCC_ONE;
      default: occ_nxt = OCC_EMPTY;
    endcase
    if (flush) occ_nxt = OCC_EMPTY;
  end

  // Control stage: occupancy, in-flight tracking and the registered stream flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      occ      <= OCC_EMPTY;
      inflight <= 1'b0;
      m_valid  <= 1'b0;
      busy     <= 1'b0;
    end else begin
      occ      <= occ_nxt;
      inflight <= fifo_rd_en;
      m_valid  <= (occ_nxt != OCC_EMPTY);
      busy     <= (occ_nxt != OCC_EMPTY) || fifo_rd_en;
    end
  end

  // Data stage: word_p0 is the head, word_p1 the tail; an arriving word fills the first free slot
  // after any same-cycle pop, so a write into ONE during a pop lands directly in the head.
  always_ff @(posedge clk) begin
    case (occ)
      OCC_EMPTY: if (inflight) word_p0 <= fifo_rdata;
      OCC_ONE: begin
        if (inflight) begin
          if (pop) word_p0 <= fifo_rdata;
          else     word_p1 <= fifo_rdata;
        end
      end
      OCC_TWO: begin
        if (pop) begin
          word_p0 <= word_p1;
          if (inflight) word_p1 <= fifo_rdata;
        end
      end
      default: ;
    endcase
  end

  // The data registers carry no reset; the head is masked so an idle stream always shows zero.
  assign m_data = m_valid ? word_p0 : '0;

`ifdef FIFO_RD_STATS_EN
  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + CNT_WIDTH'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      pop_count   <= '0;
      stall_count <= '0;
    end else begin
      if (pop)                pop_count   <= sat_inc(pop_count);
      if (m_valid && !m_ready) stall_count <= sat_inc(stall_count);
    end
  end
`endif

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(occ == OCC_TWO && inflight && !pop));

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Randomized and directed bench for fifo_rd_stream: a queue-based FIFO and buffer model predicts every output each cycle.
module tb_fifo_rd_stream;
  localparam int DW   = 8;
  localparam int CW   = 5;
  localparam int CMAX = (1 << CW) - 1;
  localparam int NOBS = 2048;

  logic          clk = 1'b0;
  logic          rst, fifo_empty, fifo_rd_en, m_valid, m_ready, flush, busy;
  logic [DW-1:0] fifo_rdata, m_data;
`ifdef FIFO_RD_STATS_EN
  logic [CW-1:0] pop_count, stall_count;
`endif

  fifo_rd_stream #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en),
    .fifo_rdata(fifo_rdata), .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready),
    .flush(flush), .busy(busy)
`ifdef FIFO_RD_STATS_EN
    , .pop_count(pop_count), .stall_count(stall_count)
`endif
  );

  always #5 clk = ~clk;

  logic [DW-1:0] fq[$];
  logic [DW-1:0] mq[$];
  logic [DW-1:0] dlv[$];
  bit            m_infl;
  logic [DW-1:0] m_infl_word;
  int            m_pops, m_stalls;
  int            checks = 0, errors = 0, cyc = 0;
  bit            rd_issued;
  bit            obs_rd[NOBS], obs_vld[NOBS], obs_busy[NOBS], obs_pop[NOBS], obs_empty[NOBS];
  logic [DW-1:0] obs_data[NOBS];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  // One clock: present inputs, compare against the model mid-cycle, advance model and FIFO.
  task automatic cycle();
    bit e_vld, e_pop, e_rd;
    logic [DW-1:0] e_data;
    int occ_m;
    fifo_empty = (fq.size() == 0);
    #4;
    occ_m  = mq.size();
    e_vld  = (occ_m != 0);
    e_data = e_vld ? mq[0] : '0;
    e_pop  = e_vld && m_ready;
    e_rd   = !fifo_empty && !flush && !rst && (occ_m + int'(m_infl) - int'(e_pop) < 2);
    chk("fifo_rd_en", 32'(fifo_rd_en), 32'(e_rd));
    chk("m_valid", 32'(m_valid), 32'(e_vld));
    chk("m_data", 32'(m_data), 32'(e_data));
    chk("busy", 32'(busy), 32'(e_vld || m_infl));
`ifdef FIFO_RD_STATS_EN
    chk("pop_count", 32'(pop_count), m_pops);
    chk("stall_count", 32'(stall_count), m_stalls);
`endif
    if (cyc < NOBS) begin
      obs_rd[cyc] = fifo_rd_en;  obs_vld[cyc] = m_valid;  obs_busy[cyc] = busy;
      obs_pop[cyc] = m_valid && m_ready;  obs_empty[cyc] = fifo_empty;  obs_data[cyc] = m_data;
    end
    if (m_valid && m_ready && !rst) dlv.push_back(m_data);
    if (rst) begin
      mq.delete(); m_infl = 0; m_pops = 0; m_stalls = 0;
    end else begin
      if (e_pop) begin
        void'(mq.pop_front());
        if (m_pops < CMAX) m_pops++;
      end
      if (e_vld && !m_ready && m_stalls < CMAX) m_stalls++;
      if (flush) begin
        mq.delete(); m_infl = 0;
      end else begin
        if (m_infl) mq.push_back(m_infl_word);
        m_infl = e_rd;
        if (e_rd) m_infl_word = fq[0];
      end
    end
    rd_issued = fifo_rd_en;
    @(posedge clk); #1;
    if (rd_issued) fifo_rdata = (fq.size() != 0) ? fq.pop_front() : '0;
    cyc++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  function automatic int count_rd(input int a, input int b);
    int n = 0;
    for (int c = a; c <= b && c < NOBS; c++) if (obs_rd[c]) n++;
    return n;
  endfunction

  function automatic int count_vld(input int a, input int b);
    int n = 0;
    for (int c = a; c <= b && c < NOBS; c++) if (obs_vld[c]) n++;
    return n;
  endfunction

  function automatic int count_pop(input int a, input int b);
    int n = 0;
    for (int c = a; c <= b && c < NOBS; c++) if (obs_pop[c]) n++;
    return n;
  endfunction

  function automatic logic [31:0] dlv_at(input int i);
    return (i < dlv.size()) ? 32'(dlv[i]) : 32'hFFFF_FFFF;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, t1, first, last, held, run_sum, maxo, viol;
    rst = 1; flush = 0; m_ready = 0; fifo_empty = 1; fifo_rdata = '0;
    m_infl = 0; m_infl_word = '0; m_pops = 0; m_stalls = 0;
    @(posedge clk); #1;
    run(2);
    chk("reset_m_valid", 32'(m_valid), 0);
    chk("reset_busy", 32'(busy), 0);
    chk("reset_m_data", 32'(m_data), 0);
    chk("reset_rd_en", 32'(fifo_rd_en), 0);
    rst = 0;
    run(1);

    // Streaming at full rate
    for (int i = 1; i <= 16; i++) fq.push_back(8'(i));
    m_ready = 1; dlv.delete(); t0 = cyc;
    run(22);
    first = -1; last = -1;
    for (int c = t0; c < cyc; c++) begin
      if (obs_vld[c] && first < 0) first = c;
      if (obs_pop[c]) last = c;
    end
    chk("stream_first_valid", 32'(first - t0), 2);
    chk("stream_count", 32'(dlv.size()), 16);
    for (int i = 0; i < 16; i++) chk("stream_word", dlv_at(i), 32'(i + 1));
    chk("stream_pop_span", 32'(last - first), 15);
    chk("stream_busy_at_last_pop", 32'(obs_busy[last]), 1);
    chk("stream_busy_after_last_pop", 32'(obs_busy[last + 1]), 0);
`ifdef FIFO_RD_STATS_EN
    chk("stream_pop_count", 32'(pop_count), 16);
    chk("stream_stall_count", 32'(stall_count), 0);
`endif

    // Backpressure: 10 stalled cycles with the head valid
    for (int i = 0; i < 8; i++) fq.push_back(8'(8'hA0 + i));
    m_ready = 0; dlv.delete(); t0 = cyc;
    run(12);
    chk("bp_reads_during_stall", 32'(count_rd(t0, t0 + 11)), 2);
    held = 0;
    for (int c = t0 + 2; c <= t0 + 11; c++) if (obs_vld[c] && obs_data[c] == 8'hA0) held++;
    chk("bp_head_held", 32'(held), 10);
`ifdef FIFO_RD_STATS_EN
    chk("bp_stall_count", 32'(stall_count), 10);
`endif
    m_ready = 1; t1 = cyc;
    run(12);
    chk("bp_no_gap", 32'(count_pop(t1, t1 + 7)), 8);
    chk("bp_count", 32'(dlv.size()), 8);
    for (int i = 0; i < 8; i++) chk("bp_word", dlv_at(i), 32'(8'hA0 + i));

    // Ready toggling
    for (int i = 0; i < 12; i++) fq.push_back(8'(8'hC0 + i));
    dlv.delete(); t0 = cyc;
    for (int i = 0; i < 40; i++) begin
      m_ready = (i % 2 == 0);
      run(1);
    end
    run_sum = 0; maxo = 0;
    for (int c = t0; c < cyc; c++) begin
      run_sum += int'(obs_rd[c]) - int'(obs_pop[c]);
      if (run_sum > maxo) maxo = run_sum;
    end
    chk("toggle_outstanding_le2", 32'(maxo <= 2), 1);
    chk("toggle_count", 32'(dlv.size()), 12);
    for (int i = 0; i < 12; i++) chk("toggle_word", dlv_at(i), 32'(8'hC0 + i));

    // Flush with a pop and an in-flight read in the same cycle
    for (int i = 0; i < 6; i++) fq.push_back(8'(8'h31 + i));
    m_ready = 0; dlv.delete();
    run(3);
    m_ready = 1;
    run(1);
    flush = 1; t1 = cyc;
    run(1);
    flush = 0;
    run(10);
    chk("flush_valid_next", 32'(obs_vld[t1 + 1]), 0);
    chk("flush_count", 32'(dlv.size()), 5);
    chk("flush_pop_in_flush_cycle", dlv_at(1), 32'h32);
    chk("flush_next_word", dlv_at(2), 32'h34);

    // Reset mid-stream with the buffer full
    for (int i = 0; i < 5; i++) fq.push_back(8'(8'h51 + i));
    m_ready = 0;
    run(3);
    rst = 1; t1 = cyc;
    run(3);
    for (int c = t1 + 1; c <= t1 + 2; c++) begin
      chk("rst_valid", 32'(obs_vld[c]), 0);
      chk("rst_busy", 32'(obs_busy[c]), 0);
      chk("rst_rd_en", 32'(obs_rd[c]), 0);
      chk("rst_data", 32'(obs_data[c]), 0);
    end
`ifdef FIFO_RD_STATS_EN
    chk("rst_pop_count", 32'(pop_count), 0);
`endif
    rst = 0; m_ready = 1; dlv.delete();
    run(8);
    chk("rst_resume_count", 32'(dlv.size()), 3);
    chk("rst_resume_head", dlv_at(0), 32'h53);

    // Single word into an empty FIFO
    run(2);
    t0 = cyc;
    fq.push_back(8'h77); dlv.delete();
    run(6);
    chk("edge_rd_pulses", 32'(count_rd(t0, t0 + 5)), 1);
    chk("edge_valid_cycles", 32'(count_vld(t0, t0 + 5)), 1);
    chk("edge_word", dlv_at(0), 32'h77);

    // Randomized traffic with occasional flush and reset
    for (int i = 0; i < 700; i++) begin
      if (fq.size() < 12 && $urandom_range(0, 99) < 55) fq.push_back(8'($urandom));
      m_ready = ($urandom_range(0, 99) < 65);
      flush   = ($urandom_range(0, 63) == 0);
      rst     = ($urandom_range(0, 255) == 0);
      run(1);
    end
    rst = 0; flush = 0; m_ready = 1;
    run(30);
    chk("drain_busy", 32'(busy), 0);
    chk("drain_valid", 32'(m_valid), 0);

    viol = 0;
    for (int c = 0; c < cyc && c < NOBS; c++) if (obs_rd[c] && obs_empty[c]) viol++;
    chk("rd_en_while_empty", 32'(viol), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
